ren_frag_depth_unit: RTL

Parametrised depth-test and framebuffer-writeback unit for the fragment stage. It accepts one row-group of up to `LANES` shaded fragments with interpolated depth, colour and a coverage mask. It fetches stored depth per active lane from the depth buffer and applies a selectable compare function. Z and colour are written back for passing lanes. It sits between the fragment shader's interpolation datapath and the depth/colour buffer memories, replacing the fixed 4-lane, less-than-only depth path.

---
 rtl/ren_params.sv | 52 +++++
 rtl/ren_fp22_cmp.sv | 39 +++
 rtl/ren_frag_depth_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ren_params.sv
// ren_params -- shared render-pipe types: fp22 depth word, depth compare codes, depth-unit FSM states.
// Rev 1.0
`default_nettype none

package ren_params;

  typedef logic [21:0] fp22_t;

  typedef enum logic [2:0] {
    DF_NEVER    = 3'd0,
    DF_LESS     = 3'd1,
    DF_EQUAL    = 3'd2,
    DF_LEQUAL   = 3'd3,
    DF_GREATER  = 3'd4,
    DF_NOTEQUAL = 3'd5,
    DF_GEQUAL   = 3'd6,
    DF_ALWAYS   = 3'd7
  } depth_func_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_COMPARE = 3'd3,
    ST_WRITE   = 3'd4,
    ST_DONE    = 3'd5
  } depth_state_e;

  localparam int MAX_LANES = 8;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    popcount8 = '0;
    for (int i = 0; i < 8; i++) popcount8 = popcount8 + {3'b000, v[i]};
  endfunction

  // Result of "incoming OP stored" given incoming<stored (lt) and incoming==stored (eq).
  function automatic logic depth_test(input depth_func_e f, input logic lt, input logic eq);
    case (f)
      DF_NEVER:    depth_test = 1'b0;
      DF_LESS:     depth_test = lt;
      DF_EQUAL:    depth_test = eq;
      DF_LEQUAL:   depth_test = lt | eq;
      DF_GREATER:  depth_test = ~lt & ~eq;
      DF_NOTEQUAL: depth_test = ~eq;
      DF_GEQUAL:   depth_test = ~lt;
      default:     depth_test = 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ren_fp22_cmp.sv
// ren_fp22_cmp -- combinational sign-magnitude compare (a<b, a==b) with +0 equal to -0.
// Rev 1.0
`default_nettype none

module ren_fp22_cmp #(
  parameter int W = 22
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt,
  output logic         eq
);

  logic         sa;
  logic         sb;
  logic [W-2:0] ma;
  logic [W-2:0] mb;
  logic         both_zero;

  assign sa        = a[W-1];
  assign sb        = b[W-1];
  assign ma        = a[W-2:0];
  assign mb        = b[W-2:0];
  assign both_zero = (ma == '0) && (mb == '0);
  assign eq        = both_zero || (a == b);

  // Negative magnitudes order in reverse.
  always_comb begin
    lt = 1'b0;
    if (!eq) begin
      if (sa != sb)  lt = sa;
      else if (!sa)  lt = (ma < mb);
      else           lt = (ma > mb);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ren_frag_depth_unit.sv
// ren_frag_depth_unit -- per-group depth fetch, selectable compare and z/colour writeback.
// Rev 1.0
`default_nettype none

module ren_frag_depth_unit
  import ren_params::*;
#(
  parameter int LANES   = 4,
  parameter int FP_W    = 22,
  parameter int COLOR_W = 24,
  parameter int ADDR_W  = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [15:0]                i_x,
  input  logic [15:0]                i_y,
  input  logic [LANES-1:0]           i_mask,
  input  logic [LANES*FP_W-1:0]      i_z,
  input  logic [LANES*COLOR_W-1:0]   i_color,
  input  logic [2:0]                 i_cmp_func,
  input  logic                       i_z_write_en,
  input  logic [ADDR_W-1:0]          i_stride,
  input  logic                       i_mem_stall,
  output logic                       o_z_rd_en,
  output logic [ADDR_W-1:0]          o_z_addr,
  input  logic [FP_W-1:0]            i_z_rdata,
  output logic                       o_z_wr_en,
  output logic [FP_W-1:0]            o_z_wdata,
  output logic                       o_c_wr_en,
  output logic [ADDR_W-1:0]          o_c_addr,
  output logic [COLOR_W-1:0]         o_c_wdata,
  output logic                       o_done,
  output logic [LANES-1:0]           o_pass_mask,
  output logic [31:0]                o_tested,
  output logic [31:0]                o_passed
);

  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  depth_state_e         state;
  depth_state_e         state_nxt;

  logic [LANES-1:0]     mask_q;
  logic [LANES-1:0]     rd_left;
  logic [LANES-1:0]     wr_left;
  logic [LANES-1:0]     pass_q;
  logic [LANES-1:0]     pass_w;
  logic [LANES-1:0]     pm_val;
  logic [LANES-1:0]     rd_rest;
  logic [LANES-1:0]     wr_rest;
  logic [FP_W-1:0]      z_q      [LANES];
  logic [FP_W-1:0]      stored_q [LANES];
  logic [COLOR_W-1:0]   col_q    [LANES];
  depth_func_e          func_q;
  depth_func_e          func_in;
  logic                 zwe_q;
  logic [ADDR_W-1:0]    base_q;
  logic [ADDR_W-1:0]    base_w;
  logic                 rd_pend;
  logic [LIDX_W-1:0]    rd_lane_q;
  logic [LIDX_W-1:0]    rd_idx;
  logic [LIDX_W-1:0]    wr_idx;
  logic [LIDX_W-1:0]    cur_idx;
  logic                 accept;
  logic                 rd_fire;
  logic                 wr_fire;
  logic                 active;
  logic [32:0]          tested_sum;
  logic [32:0]          passed_sum;

  function automatic logic [LIDX_W-1:0] lowest(input logic [LANES-1:0] v);
    lowest = '0;
    for (int k = LANES - 1; k >= 0; k--) if (v[k]) lowest = LIDX_W'(k);
  endfunction

  assign func_in = depth_func_e'(i_cmp_func);
  assign base_w  = ADDR_W'(i_y) * i_stride + ADDR_W'(i_x);
  assign accept  = i_valid && o_ready;
  assign rd_fire = (state == ST_FETCH) && !i_mem_stall;
  assign wr_fire = (state == ST_WRITE) && !i_mem_stall;
  assign rd_idx  = lowest(rd_left);
  assign wr_idx  = lowest(wr_left);
  // Clearing the lowest set bit retires the lane just serviced.
  assign rd_rest = rd_left & (rd_left - 1'b1);
  assign wr_rest = wr_left & (wr_left - 1'b1);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic lt;
    logic eq;
    ren_fp22_cmp #(.W(FP_W)) u_cmp (
      .a  (z_q[k]),
      .b  (stored_q[k]),
      .lt (lt),
      .eq (eq)
    );
    assign pass_w[k] = mask_q[k] & depth_test(func_q, lt, eq);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pm_val    = '0;
    case (state)
      ST_IDLE: begin
        if (i_valid) begin
          if (i_mask == '0)                                    state_nxt = ST_DONE;
          else if (func_in == DF_NEVER || func_in == DF_ALWAYS) state_nxt = ST_COMPARE;
          else                                                 state_nxt = ST_FETCH;
        end
      end
      ST_FETCH:   if (rd_fire && rd_rest == '0) state_nxt = ST_WAIT;
      ST_WAIT:    state_nxt = ST_COMPARE;
      ST_COMPARE: begin
        pm_val    = pass_w;
        state_nxt = (pass_w == '0) ? ST_DONE : ST_WRITE;
      end
      ST_WRITE: begin
        pm_val = pass_q;
        if (wr_fire && wr_rest == '0) state_nxt = ST_DONE;
      end
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign o_ready   = rstn && (state == ST_IDLE);
  assign active    = (state == ST_FETCH) || (state == ST_WRITE);
  assign cur_idx   = (state == ST_WRITE) ? wr_idx : rd_idx;
  assign o_z_rd_en = (state == ST_FETCH);
  assign o_c_wr_en = (state == ST_WRITE);
  assign o_z_wr_en = (state == ST_WRITE) && zwe_q;
  assign o_z_addr  = active ? base_q + ADDR_W'(cur_idx) : '0;
  assign o_c_addr  = o_z_addr;
  assign o_z_wdata = (state == ST_WRITE) ? z_q[wr_idx]   : '0;
  assign o_c_wdata = (state == ST_WRITE) ? col_q[wr_idx] : '0;
  assign o_done    = (state == ST_DONE);

  assign tested_sum = {1'b0, o_tested} + 33'(popcount8(8'(mask_q)));
  assign passed_sum = {1'b0, o_passed} + 33'(popcount8(8'(pass_w)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mask_q      <= '0;
      rd_left     <= '0;
      wr_left     <= '0;
      pass_q      <= '0;
      func_q      <= DF_NEVER;
      zwe_q       <= 1'b0;
      base_q      <= '0;
      rd_pend     <= 1'b0;
      rd_lane_q   <= '0;
      o_pass_mask <= '0;
      o_tested    <= '0;
      o_passed    <= '0;
      for (int k = 0; k < LANES; k++) begin
        z_q[k]      <= '0;
        stored_q[k] <= '0;
        col_q[k]    <= '0;
      end
    end else begin
      if (accept) begin
        mask_q  <= i_mask;
        rd_left <= i_mask;
        func_q  <= func_in;
        zwe_q   <= i_z_write_en;
        base_q  <= base_w;
        for (int k = 0; k < LANES; k++) begin
          z_q[k]   <= i_z[k*FP_W +: FP_W];
          col_q[k] <= i_color[k*COLOR_W +: COLOR_W];
        end
      end

      rd_pend <= rd_fire;
      if (rd_fire) begin
        rd_left   <= rd_rest;
        rd_lane_q <= rd_idx;
      end
      // Read data lands one cycle after the accepted request.
      if (rd_pend) stored_q[rd_lane_q] <= i_z_rdata;

      if (state == ST_COMPARE) begin
        pass_q   <= pass_w;
        wr_left  <= pass_w;
        o_tested <= tested_sum[32] ? 32'hFFFF_FFFF : tested_sum[31:0];
        o_passed <= passed_sum[32] ? 32'hFFFF_FFFF : passed_sum[31:0];
      end

      if (wr_fire) wr_left <= wr_rest;

      if (state != ST_DONE && state_nxt == ST_DONE) o_pass_mask <= pm_val;
    end
  end

endmodule

`default_nettype wire
